// File: rtl/bus_timer_pkg.sv
// Shared CPU bus definitions for the bus timer: register map, field positions, default base.
package bus_timer_pkg;

    localparam logic [31:0] BT_DEFAULT_BASE_ADDR = 32'h0000_1000;

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_COUNT   = 2'd1,
        REG_COMPARE = 2'd2,
        REG_STATUS  = 2'd3
    } reg_sel_e;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_AUTO_BIT     = 1;
    localparam int unsigned CTRL_IRQEN_BIT    = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 16;
    localparam int unsigned STATUS_MATCH_BIT  = 0;
    localparam int unsigned STATUS_OVF_BIT    = 1;

    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_flags_t;

    // 16-byte window decode; the low nibble is the register offset.
    function automatic logic window_hit(input logic [31:0] addr, input logic [31:0] base);
        return (addr >> 4) == (base >> 4);
    endfunction

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescaler for the bus timer: counts 0..limit while enabled and ticks on the limit value.
module bus_timer_prescaler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    input  logic             i_Clear,
    input  logic [WIDTH-1:0] i_Limit,
    output logic             o_Tick_c,
    output logic [WIDTH-1:0] o_Count
);

    logic [WIDTH-1:0] r_cnt;

    assign o_Tick_c = i_Enable && (r_cnt == i_Limit);
    assign o_Count  = r_cnt;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_cnt <= '0;
        end else if (i_Clear || o_Tick_c) begin
            r_cnt <= '0;
        end else if (i_Enable) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer: CTRL/COUNT/COMPARE/STATUS window with prescaled counting,
// compare match with optional auto-reload, overflow flag and level interrupt.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = BT_DEFAULT_BASE_ADDR,
    parameter int unsigned PRESCALE_WIDTH = 16
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [31:0] i_Bus_Addr,
    input  logic        i_Bus_WE,
    input  logic [31:0] i_Bus_WD,
    output logic [31:0] o_Bus_RD,
    output logic        o_IRQ
);

    localparam int unsigned PW = PRESCALE_WIDTH;

    ctrl_flags_t   r_flags;
    logic [PW-1:0] r_prescale;
    logic [31:0]   r_count;
    logic [31:0]   r_compare;
    logic          r_match;
    logic          r_ovf;

    logic          w_sel;
    reg_sel_e      w_reg;
    logic          w_wr_ctrl;
    logic          w_wr_count;
    logic          w_wr_compare;
    logic          w_wr_status;
    logic [PW-1:0] w_wd_prescale;
    logic [PW-1:0] w_pre_cnt;
    logic          w_pre_clear;
    logic          w_tick;
    logic          w_hit;
    logic          w_set_match;
    logic          w_set_ovf;
    logic [31:0]   w_count_next;
    logic          w_match_next;
    logic          w_ovf_next;
    logic [31:0]   w_rd;
    logic          w_unused;

    assign w_sel         = window_hit(i_Bus_Addr, BASE_ADDR);
    assign w_reg         = reg_sel_e'(i_Bus_Addr[3:2]);
    assign w_wr_ctrl     = i_Bus_WE & w_sel & (w_reg == REG_CTRL);
    assign w_wr_count    = i_Bus_WE & w_sel & (w_reg == REG_COUNT);
    assign w_wr_compare  = i_Bus_WE & w_sel & (w_reg == REG_COMPARE);
    assign w_wr_status   = i_Bus_WE & w_sel & (w_reg == REG_STATUS);
    assign w_wd_prescale = i_Bus_WD[CTRL_PRESCALE_LSB +: PW];
    assign w_unused      = &{1'b0, i_Bus_Addr[1:0]};

    // Restart the prescale period on COUNT writes, on disable, and when the new limit is already passed.
    assign w_pre_clear = w_wr_count
                       | (w_wr_ctrl & (~i_Bus_WD[CTRL_EN_BIT] | (w_wd_prescale < w_pre_cnt)));

    bus_timer_prescaler #(
        .WIDTH (PW)
    ) u_prescaler (
        .i_Clk    (i_Clk),
        .i_Rst    (i_Rst),
        .i_Enable (r_flags.en),
        .i_Clear  (w_pre_clear),
        .i_Limit  (r_prescale),
        .o_Tick_c (w_tick),
        .o_Count  (w_pre_cnt)
    );

    // Counter and status next-state; bus COUNT write overrides the tick's count update.
    always_comb begin
        w_hit        = (r_count == r_compare);
        w_set_match  = w_tick & w_hit;
        w_set_ovf    = w_tick & (r_count == 32'hFFFF_FFFF) & ~(w_hit & r_flags.auto_reload);
        w_count_next = r_count;
        if (w_tick) begin
            w_count_next = (w_hit && r_flags.auto_reload) ? 32'd0 : r_count + 32'd1;
        end
        if (w_wr_count) begin
            w_count_next = i_Bus_WD;
        end
        w_match_next = (r_match & ~(w_wr_status & i_Bus_WD[STATUS_MATCH_BIT])) | w_set_match;
        w_ovf_next   = (r_ovf & ~(w_wr_status & i_Bus_WD[STATUS_OVF_BIT])) | w_set_ovf;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_flags    <= '0;
            r_prescale <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_flags.en          <= i_Bus_WD[CTRL_EN_BIT];
                r_flags.auto_reload <= i_Bus_WD[CTRL_AUTO_BIT];
                r_flags.irq_en      <= i_Bus_WD[CTRL_IRQEN_BIT];
                r_prescale          <= w_wd_prescale;
            end
            if (w_wr_compare) begin
                r_compare <= i_Bus_WD;
            end
            r_count <= w_count_next;
            r_match <= w_match_next;
            r_ovf   <= w_ovf_next;
        end
    end

    // Zero-latency read mux.
    always_comb begin
        w_rd = 32'd0;
        if (w_sel) begin
            case (w_reg)
                REG_CTRL: begin
                    w_rd[CTRL_EN_BIT]                = r_flags.en;
                    w_rd[CTRL_AUTO_BIT]              = r_flags.auto_reload;
                    w_rd[CTRL_IRQEN_BIT]             = r_flags.irq_en;
                    w_rd[CTRL_PRESCALE_LSB +: PW]    = r_prescale;
                end
                REG_COUNT:   w_rd = r_count;
                REG_COMPARE: w_rd = r_compare;
                REG_STATUS: begin
                    w_rd[STATUS_MATCH_BIT] = r_match;
                    w_rd[STATUS_OVF_BIT]   = r_ovf;
                end
                default: w_rd = 32'd0;
            endcase
        end
    end

    assign o_Bus_RD = w_rd;
    assign o_IRQ    = r_flags.irq_en & (r_match | r_ovf);

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: BusTimer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, word-aligned base of the 16-byte register window.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 16, width of the prescaler counter and of CTRL.PRESCALE.
REQ-003 SHALL have port i_Clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_Bus_Addr  input  32  byte address driven by the simple bus master.
REQ-006 SHALL have port i_Bus_WE  input  1  write strobe; a write occurs on a clock edge where i_Bus_WE=1 and the address is selected.
REQ-007 SHALL have port i_Bus_WD  input  32  write data.
REQ-008 SHALL have port o_Bus_RD  output  32  read data.
REQ-009 SHALL have port o_IRQ  output  1  level interrupt request.

Function
REQ-010 SHALL be selected when i_Bus_Addr[31:4]==BASE_ADDR[31:4]; i_Bus_Addr[1:0] SHALL be ignored.
REQ-011 SHALL map offset 0x0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN, bits[16+PRESCALE_WIDTH-1:16] PRESCALE; all other bits read 0.
REQ-012 SHALL map 0x4 COUNT (32-bit, read/write), 0x8 COMPARE (32-bit, read/write), 0xC STATUS (bit0 MATCH, bit1 OVF, write-1-to-clear).
REQ-013 SHALL drive o_Bus_RD combinationally from i_Bus_Addr in the same cycle (zero latency); o_Bus_RD SHALL be 0 when not selected.
REQ-014 SHALL run the prescaler only when EN=1, counting 0..PRESCALE; a tick is generated in the cycle the prescaler equals PRESCALE, and the prescaler then returns to 0 (PRESCALE=0 gives a tick every cycle).
REQ-015 On a tick, if COUNT==COMPARE, SHALL set MATCH, and SHALL load COUNT with 0 when AUTO_RELOAD=1, else COUNT+1.
REQ-016 On a tick with COUNT==32'hFFFF_FFFF and no match reload, SHALL wrap COUNT to 0 and set OVF.
REQ-017 SHALL hold COUNT and the prescaler when EN=0; a CTRL write with EN=0 SHALL clear the prescaler.
REQ-018 A bus write to COUNT SHALL take priority over a same-cycle tick update and SHALL clear the prescaler.
REQ-019 When a STATUS write-1-to-clear coincides with a set of the same bit, set SHALL win.
REQ-020 A CTRL write changing PRESCALE to a value below the current prescaler count SHALL clear the prescaler.
REQ-021 o_IRQ SHALL equal IRQ_EN & (MATCH | OVF), registered state only, no combinational path from bus inputs.
REQ-022 Writes to a selected offset SHALL affect only that register; unselected writes SHALL be ignored.

Reset
REQ-023 While i_Rst=1, CTRL, COUNT, COMPARE, STATUS and prescaler SHALL be 0, hence o_IRQ=0; o_Bus_RD SHALL still reflect the (zeroed) registers.
REQ-024 Reset asserted mid-count SHALL clear all state immediately without waiting for a clock edge; the first tick after release SHALL require a CTRL write with EN=1.

Structure
REQ-025 Register offsets, CTRL/STATUS bit positions and the default BASE_ADDR SHALL live in the shared CPU bus package.
REQ-026 The prescaler SHALL be a sub-module TimerPrescaler (inputs enable, clear, limit; output tick).

Verification
REQ-027 Write CTRL=0x0000_0001 (EN, PRESCALE=0), COMPARE=5 -> COUNT reads 5 after 5 ticks, MATCH=1 on the 6th tick, COUNT=6.
REQ-028 CTRL=0x0003_0007 (PRESCALE=3, AUTO_RELOAD, IRQ_EN), COMPARE=2 -> COUNT steps every 4 cycles 0,1,2,0; o_IRQ rises on the reload tick.
REQ-029 Write COUNT=0xFFFF_FFFF, CTRL=0x0000_0001 -> next tick COUNT=0, STATUS=0x2; write STATUS=0x2 -> STATUS=0.
REQ-030 Write STATUS=0x1 in the same cycle MATCH sets -> MATCH reads 1; write COUNT=0x10 in a tick cycle -> COUNT reads 0x10.
REQ-031 Read addresses BASE_ADDR+0x10 and BASE_ADDR+0x5 -> 0 and COUNT respectively; write to BASE_ADDR+0x10 changes nothing.
REQ-032 Assert i_Rst between clock edges during counting -> all registers and o_IRQ 0 before next edge; no ticks until EN rewritten.
